// File: rtl/dig_stream_sampler_if.sv
// Serial telemetry link pins and bit-FIFO side outputs of dig_stream_sampler.
// The slave modport is the sampler; the master modport is the link source / FIFO consumer.
interface dig_stream_sampler_if;
   logic        dCLK;
   logic        dDAT;
   logic        dFM;
   logic        bitBufferData;
   logic        writeBuffer;
   logic        locked;
   logic        frameStart;
   logic        errLen;
   logic [15:0] frameCount;
   logic [7:0]  errCount;

   modport master (
      output dCLK, dDAT, dFM,
      input  bitBufferData, writeBuffer, locked, frameStart, errLen, frameCount, errCount
   );

   modport slave (
      input  dCLK, dDAT, dFM,
      output bitBufferData, writeBuffer, locked, frameStart, errLen, frameCount, errCount
   );
endinterface

// File: rtl/dig_stream_sampler.sv
// Oversampling front-end for the dCLK/dDAT/dFM link: sync, deglitch, frame lock, bit-FIFO writes.
// Optional macro DSS_STATS_EN adds the frameCount / errCount statistics counters.
module dig_stream_sampler #(
   parameter int FRAME_BITS = 192,
   parameter int GLITCH_LEN = 3,
   parameter int TIMEOUT    = 1023
) (
   input  logic                 clk,
   input  logic                 rst,
   dig_stream_sampler_if.slave  link
);

   localparam int              CW     = $clog2(FRAME_BITS + 1);
   localparam logic [CW-1:0]   FB     = CW'(FRAME_BITS);
   localparam logic [3:0]      GL_MAX = 4'(GLITCH_LEN - 1);
   localparam logic [15:0]     TO     = 16'(TIMEOUT);
   localparam logic [15:0]     TO_M1  = 16'(TIMEOUT - 1);

   typedef enum logic {HUNT, LOCKED} state_t;

   // bit 0 = dCLK, bit 1 = dDAT, bit 2 = dFM
   logic [2:0]    raw;
   logic [2:0]    sync_p0;
   logic [2:0]    sync_p1;
   logic [2:0]    filt;
   logic [3:0]    fcnt [3];
   logic          clk_prev;
   logic          edge_evt;
   logic          full;
   logic          len_err;

   state_t        state;
   logic [CW-1:0] bit_cnt;
   logic [15:0]   tcnt;
   logic          bit_data;
   logic          write;
   logic          locked;
   logic          frame_start;
   logic          err_len;

   assign raw = {link.dFM, link.dDAT, link.dCLK};

   // Synchroniser and glitch filter stage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_p0  <= '0;
         sync_p1  <= '0;
         filt     <= '0;
         clk_prev <= 1'b0;
         for (int i = 0; i < 3; i++) fcnt[i] <= '0;
      end else begin
         sync_p0  <= raw;
         sync_p1  <= sync_p0;
         clk_prev <= filt[0];
         for (int i = 0; i < 3; i++) begin
            if (sync_p1[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == GL_MAX) begin
               filt[i] <= sync_p1[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + 4'd1;
            end
         end
      end
   end

   assign edge_evt = filt[0] & ~clk_prev;
   assign full     = (bit_cnt == FB);
   // Short frame (marker early) and long frame (marker missing) share one error path
   assign len_err  = edge_evt && (state == LOCKED) && (filt[2] != full);

   // Frame lock FSM stage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= HUNT;
         bit_cnt     <= '0;
         tcnt        <= '0;
         bit_data    <= 1'b0;
         write       <= 1'b0;
         locked      <= 1'b0;
         frame_start <= 1'b0;
         err_len     <= 1'b0;
      end else begin
         write       <= 1'b0;
         frame_start <= 1'b0;
         err_len     <= len_err;
         if (edge_evt) begin
            tcnt <= '0;
            if (filt[2]) begin
               write       <= 1'b1;
               bit_data    <= filt[1];
               frame_start <= 1'b1;
               bit_cnt     <= CW'(1);
               state       <= LOCKED;
               locked      <= 1'b1;
            end else if (state == LOCKED && !full) begin
               write    <= 1'b1;
               bit_data <= filt[1];
               bit_cnt  <= bit_cnt + CW'(1);
            end else if (state == LOCKED) begin
               state  <= HUNT;
               locked <= 1'b0;
            end
         end else begin
            if (tcnt != TO) tcnt <= tcnt + 16'd1;
            if (state == LOCKED && tcnt == TO_M1) begin
               state  <= HUNT;
               locked <= 1'b0;
            end
         end
      end
   end

   assign link.bitBufferData = bit_data;
   assign link.writeBuffer   = write;
   assign link.locked        = locked;
   assign link.frameStart    = frame_start;
   assign link.errLen        = err_len;

`ifdef DSS_STATS_EN
   logic        frame_ok;
   logic [15:0] frame_cnt;
   logic [7:0]  err_cnt;

   assign frame_ok = edge_evt && (state == LOCKED) && filt[2] && full;

   // Statistics stage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         if (frame_ok) frame_cnt <= frame_cnt + 16'd1;
         if (len_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end

   assign link.frameCount = frame_cnt;
   assign link.errCount   = err_cnt;
`else
   assign link.frameCount = '0;
   assign link.errCount   = '0;
`endif

endmodule

// File: tb/tb_dig_stream_sampler.sv
// Scoreboard bench for dig_stream_sampler: a bit-level frame model queues expected FIFO events,
// a monitor pops and compares them whenever writeBuffer or errLen fires.
module tb_dig_stream_sampler;

   localparam int FRAME_BITS = 8;
   localparam int GLITCH_LEN = 3;
   localparam int TIMEOUT    = 1023;
   localparam int LAT        = GLITCH_LEN + 3;
`ifdef DSS_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      int cyc;
      bit wr;
      bit dat;
      bit fs;
      bit err;
      bit lk;
      int fc;
      int ec;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   exp_t q[$];
   exp_t me;

   bit m_locked = 1'b0;
   int m_cnt = 0;
   int m_frames = 0;
   int m_errs = 0;
   int m_last = 0;

   dig_stream_sampler_if link();

   dig_stream_sampler #(
      .FRAME_BITS(FRAME_BITS),
      .GLITCH_LEN(GLITCH_LEN),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .link(link)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic void chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Frame rules applied to one received bit; pushes what the FIFO side should see
   function automatic void model_edge(input bit dat, input bit fm, input int at);
      exp_t e;
      bit   push = 1'b0;
      e.cyc = at; e.dat = dat; e.wr = 1'b0; e.fs = 1'b0; e.err = 1'b0;
      if (!m_locked) begin
         if (fm) begin
            e.wr = 1'b1; e.fs = 1'b1; m_locked = 1'b1; m_cnt = 1; push = 1'b1;
         end
      end else if (fm) begin
         e.wr = 1'b1; e.fs = 1'b1; push = 1'b1;
         if (m_cnt == FRAME_BITS) m_frames++;
         else begin e.err = 1'b1; m_errs++; end
         m_cnt = 1;
      end else if (m_cnt < FRAME_BITS) begin
         e.wr = 1'b1; push = 1'b1; m_cnt++;
      end else begin
         e.err = 1'b1; push = 1'b1; m_errs++; m_locked = 1'b0;
      end
      if (push) begin
         e.lk = m_locked;
         e.fc = STATS ? (m_frames % 65536) : 0;
         e.ec = STATS ? ((m_errs > 255) ? 255 : m_errs) : 0;
         q.push_back(e);
         m_last = at;
      end
   endfunction

   always @(negedge clk) begin
      if (rst && (link.writeBuffer || link.errLen)) begin
         chk("event_expected", int'(q.size() > 0), 1);
         if (q.size() > 0) begin
            me = q.pop_front();
            chk("event_cycle", cyc, me.cyc);
            chk("writeBuffer", int'(link.writeBuffer), int'(me.wr));
            if (me.wr) chk("bitBufferData", int'(link.bitBufferData), int'(me.dat));
            chk("frameStart", int'(link.frameStart), int'(me.fs));
            chk("errLen", int'(link.errLen), int'(me.err));
            chk("locked", int'(link.locked), int'(me.lk));
            chk("frameCount", int'(link.frameCount), me.fc);
            chk("errCount", int'(link.errCount), me.ec);
         end
      end
   end

   task automatic send_bit(input bit dat, input bit fm, input int lo, input int hi);
      link.dCLK = 1'b0; link.dDAT = dat; link.dFM = fm;
      repeat (lo) @(negedge clk);
      link.dCLK = 1'b1;
      model_edge(dat, fm, cyc + LAT);
      repeat (hi) @(negedge clk);
   endtask

   task automatic pulse(input int n);
      link.dCLK = 1'b0;
      repeat (8) @(negedge clk);
      link.dCLK = 1'b1;
      if (n >= GLITCH_LEN) model_edge(link.dDAT, link.dFM, cyc + LAT);
      repeat (n) @(negedge clk);
      link.dCLK = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] v, input int lo, input int hi);
      for (int i = 0; i < 8; i++) send_bit(v[7-i], i == 0, lo, hi);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_writeBuffer"}, int'(link.writeBuffer), 0);
      chk({tag, "_bitBufferData"}, int'(link.bitBufferData), 0);
      chk({tag, "_locked"}, int'(link.locked), 0);
      chk({tag, "_frameStart"}, int'(link.frameStart), 0);
      chk({tag, "_errLen"}, int'(link.errLen), 0);
      chk({tag, "_frameCount"}, int'(link.frameCount), 0);
      chk({tag, "_errCount"}, int'(link.errCount), 0);
   endtask

   initial begin
      bit fm;
      link.dCLK = 1'b0; link.dDAT = 1'b0; link.dFM = 1'b0;
      repeat (4) @(negedge clk);
      check_idle("reset");
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 12, 12);
      chk("hunt_locked", int'(link.locked), 0);

      send_frame(8'hA5, 12, 12);

      send_bit(1'b1, 1'b1, 10, 10);
      for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 10, 10);
      pulse(2);
      pulse(3);
      for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 10, 10);

      send_bit(1'b0, 1'b1, 8, 8);
      for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 8, 8);
      send_bit(1'b1, 1'b1, 8, 8);
      for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 8, 8);
      send_bit(1'b1, 1'b0, 8, 8);
      chk("long_frame_locked", int'(link.locked), 0);

      for (int i = 0; i < 200; i++) begin
         fm = (m_locked && m_cnt == FRAME_BITS) ? ($urandom_range(0, 3) != 0)
                                                 : ($urandom_range(0, 9) == 0);
         send_bit(1'($urandom_range(0, 1)), fm, $urandom_range(4, 12), $urandom_range(3, 10));
      end

      send_bit(1'b1, 1'b1, 8, 8);
      send_bit(1'b0, 1'b0, 8, 8);
      send_bit(1'b1, 1'b0, 8, 12);
      for (int k = 0; k < 1100 && link.locked; k++) @(negedge clk);
      chk("timeout_cycle", cyc, m_last + TIMEOUT);
      chk("timeout_locked", int'(link.locked), 0);
      m_locked = 1'b0;

      send_bit(1'b1, 1'b1, 8, 8);
      for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 8, 8);
      link.dCLK = 1'b0;
      repeat (8) @(negedge clk);
      chk("queue_drained_before_reset", q.size(), 0);
      rst = 1'b0;
      #1;
      check_idle("midframe_reset");
      @(negedge clk);
      rst = 1'b1;
      m_locked = 1'b0; m_cnt = 0; m_frames = 0; m_errs = 0;
      for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 8, 8);
      chk("post_reset_locked", int'(link.locked), 0);

      for (int i = 0; i < 3; i++) send_frame(8'($urandom), 6, 6);
      chk("frameCount_three_frames", int'(link.frameCount), STATS ? 2 : 0);
      for (int i = 0; i < 301; i++) send_bit(1'($urandom_range(0, 1)), 1'b1, 5, 6);
      chk("errCount_saturated", int'(link.errCount), STATS ? 255 : 0);

      repeat (20) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
